// File: rtl/mem_access_master.sv
// Load/store initiator for an 8-cycle, byte-addressed, 64-bit data memory.
// One access outstanding; sub-doubleword stores are done as read-modify-write.
module mem_access_master #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024,
  parameter int WR_LAT    = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_error,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_MemRead,
  output logic              o_MemWrite,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data
);

  localparam int CNT_MAX = (TIMEOUT > WR_LAT) ? TIMEOUT : WR_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(WR_LAT);
  localparam logic [ADDR_W:0]   LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, RD_REQ, RD_WAIT, MERGE, WR_REQ, WR_WAIT, DONE
  } state_e;

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  oaddr_q, oaddr_d;
  logic [DATA_W-1:0]  odata_q, odata_d;

  logic               misaligned, out_of_range;
  logic [ADDR_W:0]    addr_end;
  logic [DATA_W-1:0]  byte_mask;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] sz,
                                               input logic uns);
    case (sz)
      2'd0:    return {{(DATA_W-8){d[7] & ~uns}}, d[7:0]};
      2'd1:    return {{(DATA_W-16){d[15] & ~uns}}, d[15:0]};
      2'd2:    return {{(DATA_W-32){d[31] & ~uns}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    case (size_q)
      2'd0:    byte_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
      2'd1:    byte_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      2'd2:    byte_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      default: byte_mask = '1;
    endcase
    misaligned   = (addr_q[2:0] & ((3'd1 << size_q) - 3'd1)) != 3'd0;
    addr_end     = {1'b0, addr_q} + (ADDR_W+1)'(7);
    out_of_range = addr_end > LAST_BYTE;
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (i_req_valid && ready_q) begin
        write_d = i_req_write;
        size_d  = i_req_size;
        uns_d   = i_req_unsigned;
        addr_d  = i_req_addr;
        wdata_d = i_req_wdata;
        err_d   = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        if (misaligned || out_of_range) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (write_q && size_q == 2'd3) begin
          state_d = WR_REQ;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_valid) begin
          data_d  = i_data;
          state_d = write_q ? MERGE : DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MERGE: begin
        data_d  = (data_q & ~byte_mask) | (wdata_q & byte_mask);
        state_d = WR_REQ;
      end
      WR_REQ: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (cnt_q == WR_LAST) state_d = DONE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d = (state_d == IDLE);
    rd_d    = (state_d == RD_REQ);
    wr_d    = (state_d == WR_REQ);
    done_d  = (state_d == DONE);
    error_d = done_d & err_d;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    rdata_d = rdata_q;
    if (rd_d || wr_d) oaddr_d = addr_q;
    if (wr_d)         odata_d = (size_q == 2'd3) ? wdata_q : data_d;
    if (done_d)       rdata_d = (err_d || write_q) ? '0 : extend(data_d, size_q, uns_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_rdata    = rdata_q;
  assign o_MemRead  = rd_q;
  assign o_MemWrite = wr_q;
  assign o_addr     = oaddr_q;
  assign o_data     = odata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: byte-array memory device plus a byte-level
// reference model of load/store semantics and latency.
module tb_mem_access_master;
  localparam int MEMB = 1024;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_uns;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        o_ready, o_done, o_error, o_MemRead, o_MemWrite;
  logic [63:0] o_rdata, o_addr, o_data;
  logic        i_valid;
  logic [63:0] i_data;

  always #5 clk = ~clk;

  mem_access_master #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(MEMB), .WR_LAT(8), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write(req_write),
    .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_ready(o_ready), .o_done(o_done), .o_error(o_error),
    .o_rdata(o_rdata), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_addr(o_addr),
    .o_data(o_data), .i_valid(i_valid), .i_data(i_data)
  );

  int checks = 0, errors = 0;
  byte unsigned dev_mem[MEMB];
  byte unsigned ref_mem[MEMB];
  bit resp_en = 1'b1;

  // observations of one transaction
  int          lat, nrd, nwr, busy_bad, strobe_bad;
  logic        obs_err, ready_after, done_after;
  logic [63:0] obs_rdata, wr_addr, wr_data, rd_addr;
  // reference expectations
  logic        exp_err;
  logic [63:0] exp_rdata, exp_img;
  int          exp_lat, exp_nrd, exp_nwr;

  function automatic logic [63:0] dev_rd(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = dev_mem[int'((a + 64'(i)) % 64'(MEMB))];
    return r;
  endfunction

  task automatic dev_wr(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) dev_mem[int'((a + 64'(i)) % 64'(MEMB))] = d[8*i +: 8];
  endtask

  // Byte-level semantics: what a load returns, what a store leaves in memory.
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd);
    int nb = 1 << sz;
    longint unsigned a = addr;
    logic [63:0] v;
    exp_err = ((a % longint'(nb)) != 0) || (a + 7 > MEMB - 1);
    exp_rdata = '0; exp_img = '0; exp_nrd = 0; exp_nwr = 0;
    if (exp_err) exp_lat = 2;
    else if (!wr) begin
      exp_lat = 11; exp_nrd = 1; v = '0;
      for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
      if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      exp_rdata = v;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      for (int i = 0; i < 8; i++) exp_img[8*i +: 8] = ref_mem[int'(a) + i];
      exp_nwr = 1; exp_nrd = (nb == 8) ? 0 : 1; exp_lat = (nb == 8) ? 12 : 22;
    end
  endtask

  // Watches one accepted transaction and plays the memory device.
  task automatic observe(input int budget);
    int rd_due = -1;
    lat = -1; nrd = 0; nwr = 0; busy_bad = 0; strobe_bad = 0; obs_err = 1'bx; obs_rdata = 'x;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == rd_due && resp_en) begin i_valid = 1'b1; i_data = dev_rd(rd_addr); end
      else i_valid = 1'b0;
      @(negedge clk);
      if (o_MemRead && o_MemWrite) strobe_bad++;
      if (o_MemRead)  begin nrd++; rd_addr = o_addr; rd_due = k + 8; end
      if (o_MemWrite) begin nwr++; wr_addr = o_addr; wr_data = o_data; dev_wr(o_addr, o_data); end
      if (o_done) begin lat = k; obs_err = o_error; obs_rdata = o_rdata; break; end
      if (o_ready) busy_bad++;
    end
    @(posedge clk); #1; i_valid = 1'b0;
    @(negedge clk); ready_after = o_ready; done_after = o_done;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd);
    logic rdy;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk); rdy = o_ready;
      @(posedge clk);
      if (rdy) break;
    end
    #1; req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input int budget);
    model(wr, sz, uns, addr, wd);
    issue(wr, sz, uns, addr, wd);
    observe(budget);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0; i_valid = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
    checks++; if ({o_done, o_error, o_MemRead, o_MemWrite} !== 4'b0) begin
      errors++; $display("FAIL rst_flags got=%b exp=0000", {o_done, o_error, o_MemRead, o_MemWrite}); end
    checks++; if ({o_rdata, o_addr, o_data} !== 192'd0) begin
      errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", o_rdata, o_addr, o_data); end
    #1 rst = 1'b0;
  endtask

  task automatic test_double_store_load();
    run_txn(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 100);
    checks++; if (lat !== 12) begin errors++; $display("FAIL dst_lat got=%0d exp=12", lat); end
    checks++; if (nwr !== 1 || nrd !== 0) begin errors++; $display("FAIL dst_strobes got=rd%0d/wr%0d exp=rd0/wr1", nrd, nwr); end
    checks++; if (wr_data !== 64'h1122334455667788 || wr_addr !== 64'h10) begin
      errors++; $display("FAIL dst_wdata got=%h@%h exp=1122334455667788@10", wr_data, wr_addr); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL dst_err got=%b exp=0", obs_err); end
    checks++; if (busy_bad !== 0 || ready_after !== 1'b1 || done_after !== 1'b0) begin
      errors++; $display("FAIL dst_handshake got=busy%0d/rdy%b/done%b exp=0/1/0", busy_bad, ready_after, done_after); end
    run_txn(1'b0, 2'd3, 1'b1, 64'h10, 64'h0, 100);
    checks++; if (lat !== 11) begin errors++; $display("FAIL dld_lat got=%0d exp=11", lat); end
    checks++; if (obs_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL dld_rdata got=%h exp=1122334455667788", obs_rdata); end
  endtask

  task automatic test_sub_loads();
    run_txn(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, 100);
    checks++; if (obs_rdata !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffffffffffff88", obs_rdata); end
    run_txn(1'b0, 2'd0, 1'b1, 64'h10, 64'h0, 100);
    checks++; if (obs_rdata !== 64'h88) begin errors++; $display("FAIL lbu_rdata got=%h exp=88", obs_rdata); end
    run_txn(1'b0, 2'd1, 1'b0, 64'h16, 64'h0, 100);
    checks++; if (obs_rdata !== 64'h1122 || lat !== 11) begin
      errors++; $display("FAIL lh_rdata got=%h lat%0d exp=1122 lat11", obs_rdata, lat); end
  endtask

  task automatic test_byte_rmw();
    run_txn(1'b1, 2'd0, 1'b0, 64'h10, 64'hAB, 100);
    checks++; if (nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL rmw_strobes got=rd%0d/wr%0d exp=rd1/wr1", nrd, nwr); end
    checks++; if (wr_data !== 64'h11223344556677AB) begin errors++; $display("FAIL rmw_wdata got=%h exp=11223344556677ab", wr_data); end
    checks++; if (lat !== 22 || obs_rdata !== 64'h0) begin errors++; $display("FAIL rmw_done got=lat%0d/%h exp=lat22/0", lat, obs_rdata); end
    run_txn(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 100);
    checks++; if (obs_rdata !== 64'h11223344556677AB) begin errors++; $display("FAIL rmw_readback got=%h exp=11223344556677ab", obs_rdata); end
  endtask

  task automatic test_errors();
    run_txn(1'b0, 2'd2, 1'b0, 64'h12, 64'h0, 100);
    checks++; if (lat !== 2 || obs_err !== 1'b1 || obs_rdata !== 64'h0 || nrd + nwr !== 0) begin
      errors++; $display("FAIL misalign got=lat%0d/err%b/%h/strb%0d exp=lat2/err1/0/strb0", lat, obs_err, obs_rdata, nrd + nwr); end
    run_txn(1'b0, 2'd3, 1'b0, 64'd1020, 64'h0, 100);
    checks++; if (lat !== 2 || obs_err !== 1'b1 || obs_rdata !== 64'h0 || nrd + nwr !== 0) begin
      errors++; $display("FAIL range got=lat%0d/err%b/%h/strb%0d exp=lat2/err1/0/strb0", lat, obs_err, obs_rdata, nrd + nwr); end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    run_txn(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 200);
    resp_en = 1'b1;
    checks++; if (lat !== 3 + TO || obs_err !== 1'b1 || obs_rdata !== 64'h0 || nrd !== 1) begin
      errors++; $display("FAIL timeout got=lat%0d/err%b/%h/rd%0d exp=lat%0d/err1/0/rd1", lat, obs_err, obs_rdata, nrd, 3 + TO); end
    run_txn(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 100);
    checks++; if (lat !== 11 || obs_err !== 1'b0 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL after_timeout got=lat%0d/err%b/%h exp=lat11/err0/%h", lat, obs_err, obs_rdata, exp_rdata); end
  endtask

  task automatic test_spurious_valid();
    int bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; i_valid = 1'b1; i_data = {$urandom, $urandom};
      @(negedge clk);
      if (o_done || o_MemRead || o_MemWrite || !o_ready) bad++;
    end
    @(posedge clk); #1; i_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL spurious_idle got=%0d exp=0", bad); end
    run_txn(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 100);
    checks++; if (lat !== 11 || obs_rdata !== 64'h11223344556677AB) begin
      errors++; $display("FAIL spurious_load got=lat%0d/%h exp=lat11/11223344556677ab", lat, obs_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic wr = 1'($urandom);
      logic [1:0] sz = 2'($urandom);
      logic uns = 1'($urandom);
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] addr;
      if ($urandom_range(0, 9) < 8) addr = 64'($urandom_range(64, 1008)) & ~((64'd1 << sz) - 64'd1);
      else addr = 64'($urandom_range(0, 1030));
      run_txn(wr, sz, uns, addr, wd, 100);
      checks++; if (lat !== exp_lat || obs_err !== exp_err) begin
        errors++; $display("FAIL rnd%0d_lat got=lat%0d/err%b exp=lat%0d/err%b", n, lat, obs_err, exp_lat, exp_err); end
      checks++; if (obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, obs_rdata, exp_rdata); end
      checks++; if (nrd !== exp_nrd || nwr !== exp_nwr || strobe_bad !== 0) begin
        errors++; $display("FAIL rnd%0d_strobes got=rd%0d/wr%0d/both%0d exp=rd%0d/wr%0d/both0", n, nrd, nwr, strobe_bad, exp_nrd, exp_nwr); end
      if (exp_nwr == 1) begin
        checks++; if (wr_data !== exp_img || wr_addr !== addr) begin
          errors++; $display("FAIL rnd%0d_wdata got=%h@%h exp=%h@%h", n, wr_data, wr_addr, exp_img, addr); end
      end
      checks++; if (busy_bad !== 0 || ready_after !== 1'b1 || done_after !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_handshake got=busy%0d/rdy%b/done%b exp=0/1/0", n, busy_bad, ready_after, done_after); end
    end
  endtask

  task automatic test_reset_abort();
    logic rdy;
    int wr_seen = 0, done_seen = 0, rdy_seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_uns = 1'b0;
    req_addr = 64'h300; req_wdata = {$urandom, $urandom};
    for (int w = 0; w < 50; w++) begin
      @(negedge clk); rdy = o_ready;
      @(posedge clk);
      if (rdy) break;
    end
    #1; req_write = 1'b0; req_uns = 1'b1; req_addr = 64'h10;  // held load while busy
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (o_MemWrite) begin wr_seen++; dev_wr(o_addr, o_data); end
      if (o_done) done_seen++;
      if (o_ready) rdy_seen++;
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    if (o_done) done_seen++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (wr_seen !== 1 || done_seen !== 0 || rdy_seen !== 0) begin
      errors++; $display("FAIL abort_busy got=wr%0d/done%0d/rdy%0d exp=wr1/done0/rdy0", wr_seen, done_seen, rdy_seen); end
    checks++; if (o_ready !== 1'b1 || {o_done, o_error, o_MemRead, o_MemWrite} !== 4'b0) begin
      errors++; $display("FAIL abort_flags got=rdy%b/%b exp=rdy1/0000", o_ready, {o_done, o_error, o_MemRead, o_MemWrite}); end
    checks++; if ({o_rdata, o_addr, o_data} !== 192'd0) begin
      errors++; $display("FAIL abort_data got=%h/%h/%h exp=0", o_rdata, o_addr, o_data); end
    @(posedge clk); #1; req_valid = 1'b0;
    observe(100);
    checks++; if (lat !== 11 || obs_rdata !== 64'h11223344556677AB || nrd !== 1 || nwr !== 0) begin
      errors++; $display("FAIL held_load got=lat%0d/%h/rd%0d/wr%0d exp=lat11/11223344556677ab/rd1/wr0", lat, obs_rdata, nrd, nwr); end
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    test_reset();
    test_double_store_load();
    test_sub_loads();
    test_byte_rmw();
    test_errors();
    test_timeout();
    test_spurious_valid();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- CPU-side initiator for the 8-cycle, byte-addressed, 64-bit data memory.
- Accepts one load/store request from the pipeline, issues a single-cycle o_MemRead/o_MemWrite strobe, and tracks memory latency.
- Performs read-modify-write for sub-doubleword stores, and sign/zero-extends loads.
- Holds o_ready low while a request is outstanding, so the pipeline stalls.

Parameters:
ADDR_W, 64, byte address width
DATA_W, 64, data width; must be 64
MEM_BYTES, 1024, memory size in bytes; used for range check
WR_LAT, 8, cycles after the write strobe before the memory has committed and returned to idle
TIMEOUT, 64, maximum cycles from read strobe to i_valid before an error is flagged

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, synchronous, active-high
i_req_valid  in  1  request present; accepted when i_req_valid & o_ready
i_req_write  in  1  1 = store, 0 = load
i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
i_req_unsigned  in  1  load zero-extend when 1; ignored for stores
i_req_addr  in  ADDR_W  byte address
i_req_wdata  in  DATA_W  store data, low bytes significant
o_ready  out  1  idle, can accept a request
o_done  out  1  one-cycle completion pulse
o_error  out  1  valid with o_done: misaligned, out-of-range or timeout
o_rdata  out  DATA_W  load result, valid with o_done; 0 for stores and errors
o_MemRead  out  1  one-cycle read strobe to memory
o_MemWrite  out  1  one-cycle write strobe to memory
o_addr  out  ADDR_W  memory address, valid with the strobe
o_data  out  DATA_W  memory write data, valid with o_MemWrite
i_valid  in  1  memory read-data valid
i_data  in  DATA_W  memory read data

Behaviour:
- Reset: state IDLE; o_ready=1; o_done, o_error, o_MemRead, o_MemWrite = 0; o_rdata, o_addr, o_data = 0; counters = 0.
  - Reset in any state aborts the operation with no o_done.
  - The memory must be reset alongside the master.
- All outputs are registered.
- Strobes are high for exactly one cycle and never both high together.
- o_addr/o_data hold their last value between strobes.
- States: IDLE, CHECK, RD_REQ, RD_WAIT, MERGE, WR_REQ, WR_WAIT, DONE.
- IDLE, cycle 0: on accept, latch the request, drop o_ready, go to CHECK.
- CHECK, cycle 1, error conditions:
  - misaligned: addr mod 2^size != 0;
  - out of range: addr+7 > MEM_BYTES-1.
  - Either condition → DONE with error and no strobe.
  - Otherwise: load or sub-double store → RD_REQ; double store → WR_REQ.
- RD_REQ: o_MemRead=1, o_addr=addr (cycle 2). Go to RD_WAIT and clear the timeout counter.
- RD_WAIT: wait for i_valid, expected in cycle 10.
  - On i_valid, capture i_data. Load → DONE; RMW store → MERGE.
  - If the counter reaches TIMEOUT with no i_valid → DONE with error.
- MERGE: replace the low 2^size bytes of the captured data with the low 2^size bytes of wdata; upper bytes unchanged. Go to WR_REQ.
- WR_REQ: o_MemWrite=1, o_addr=addr, o_data=merged or wdata. Go to WR_WAIT.
- WR_WAIT: count WR_LAT cycles, then go to DONE.
- DONE: o_done=1 for one cycle.
  - o_rdata = low 2^size bytes of the captured data, sign-extended from bit 8·2^size−1, or zero-extended if unsigned. Size 3 passes through.
  - Return to IDLE; o_ready=1 in the following cycle.
- Latency from accept (cycle 0) to o_done:
  - load: 11
  - double store: 12
  - sub-double store: 22
  - error in CHECK: 2
- Exactly one outstanding access. No strobe is issued unless the memory is idle, which WR_LAT guarantees.
- i_valid outside RD_WAIT is ignored and has no state effect.
- i_req_valid while o_ready=0 is ignored; the requester must hold the request.
- A new request may be accepted in the cycle after o_done.

Test Plan:
- Double store addr 0x10, wdata 0x1122334455667788, then unsigned double load 0x10 → exactly one o_MemWrite, o_done 12 cycles after accept, o_error=0; load o_done 11 cycles after accept with o_rdata=0x1122334455667788.
- After the above, signed byte load addr 0x10 → o_rdata=0xFFFFFFFFFFFFFF88; unsigned → 0x88; signed half at 0x16 → 0x0000000000001122.
- Byte store wdata 0xAB to 0x10 (RMW) → o_MemRead, then o_MemWrite with o_data=0x11223344556677AB; o_done at 22; double load returns 0x11223344556677AB.
- Misaligned word load addr 0x12, and double load addr 1020 → o_done at cycle 2 with o_error=1, o_rdata=0, no strobes.
- Load with the bench never asserting i_valid → o_done with o_error=1 exactly TIMEOUT cycles after entering RD_WAIT; the next request is accepted normally.
- i_rst pulsed during WR_WAIT, plus a spurious i_valid in IDLE and i_req_valid held while busy → outputs return to reset values, no o_done, no duplicate strobes, and the request is accepted only when o_ready=1.
